// File: rtl/openflow_pkg.sv
// rtl/openflow_pkg.sv - shared TUSER field offsets and arbiter FSM encoding
package openflow_pkg;

  localparam int LEN_LO = 0;
  localparam int SPT_LO = 16;
  localparam int DPT_LO = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin search starting at ptr+1
module rr_priority_picker #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found_o && req_i[(int'(ptr_i) + k) % N]) begin
        found_o = 1'b1;
        idx_o   = PW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/openflow_input_arbiter.sv
// rtl/openflow_input_arbiter.sv - packet-granular N-port round-robin AXI-Stream merger with SPT stamping
// Optional per-port packet counters on pkt_count when OF_ARB_STATS_EN is defined.
module openflow_input_arbiter
  import openflow_pkg::*;
#(
  parameter int C_NUM_PORTS           = 5,
  parameter int C_AXIS_DATA_WIDTH     = 64,
  parameter int C_AXIS_TUSER_WIDTH    = 128,
  parameter int C_AXIS_SPT_DATA_WIDTH = 8,
  parameter int C_STAT_WIDTH          = 32
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tvalid,
  output logic [C_NUM_PORTS-1:0]                      s_axis_tready,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  output logic [$clog2(C_NUM_PORTS)-1:0]              grant_port
`ifdef OF_ARB_STATS_EN
  ,
  output logic [C_NUM_PORTS*C_STAT_WIDTH-1:0]         pkt_count
`endif
);

  localparam int PW = $clog2(C_NUM_PORTS);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int TW = C_AXIS_TUSER_WIDTH;
  localparam int PTW = C_AXIS_SPT_DATA_WIDTH;

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   grant_q, ptr_q, pick_idx;
  logic            pick_found;
  logic            first_q;
  logic            grant_rdy, beat_acc;
  logic [DW-1:0]   m_tdata_q, in_data;
  logic [SW-1:0]   m_tstrb_q, in_strb;
  logic [TW-1:0]   m_tuser_q, in_user, beat_user;
  logic            m_tvalid_q, m_tlast_q, in_last;
  logic [PTW-1:0]  spt_onehot;

  rr_priority_picker #(.N(C_NUM_PORTS), .PW(PW)) u_picker (
    .req_i  (s_axis_tvalid),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  assign in_data = s_axis_tdata[int'(grant_q)*DW +: DW];
  assign in_strb = s_axis_tstrb[int'(grant_q)*SW +: SW];
  assign in_user = s_axis_tuser[int'(grant_q)*TW +: TW];
  assign in_last = s_axis_tlast[grant_q];

  // Ready is gated during reset so no input beat is consumed by a cycle that gets discarded.
  assign grant_rdy = !areset && (!m_tvalid_q || m_axis_tready);

  always_ff @(posedge aclk) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = '0;
    beat_acc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) state_d = ST_SEND;
      end
      ST_SEND: begin
        s_axis_tready[grant_q] = grant_rdy;
        beat_acc = grant_rdy && s_axis_tvalid[grant_q];
        if (beat_acc && in_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spt_onehot          = '0;
    spt_onehot[grant_q] = 1'b1;
    beat_user           = in_user;
    if (first_q) beat_user[SPT_LO +: PTW] = spt_onehot;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      grant_q    <= '0;
      ptr_q      <= PW'(C_NUM_PORTS - 1);
      first_q    <= 1'b1;
      m_tdata_q  <= '0;
      m_tstrb_q  <= '0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && pick_found) grant_q <= pick_idx;
      if (beat_acc) begin
        m_tdata_q  <= in_data;
        m_tstrb_q  <= in_strb;
        m_tuser_q  <= beat_user;
        m_tlast_q  <= in_last;
        m_tvalid_q <= 1'b1;
        first_q    <= in_last;
        if (in_last) ptr_q <= grant_q;
      end else if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tstrb  = m_tstrb_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign grant_port    = grant_q;

`ifdef OF_ARB_STATS_EN
  logic [C_STAT_WIDTH-1:0] cnt_q [C_NUM_PORTS];

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < C_NUM_PORTS; i++) cnt_q[i] <= '0;
    end else if (beat_acc && in_last) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + C_STAT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_cnt
    assign pkt_count[g*C_STAT_WIDTH +: C_STAT_WIDTH] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_openflow_input_arbiter.sv
// tb/tb_openflow_input_arbiter.sv - scoreboard bench for openflow_input_arbiter (stats checks with OF_ARB_STATS_EN)
module tb_openflow_input_arbiter;

  localparam int N   = 5;
  localparam int DW  = 64;
  localparam int SB  = DW / 8;
  localparam int TU  = 128;
  localparam int STW = 4;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [N*DW-1:0] s_axis_tdata;
  logic [N*SB-1:0] s_axis_tstrb;
  logic [N*TU-1:0] s_axis_tuser;
  logic [N-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic [SB-1:0]   m_axis_tstrb;
  logic [TU-1:0]   m_axis_tuser;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [$clog2(N)-1:0] grant_port;
`ifdef OF_ARB_STATS_EN
  logic [N*STW-1:0] pkt_count;
`endif

  openflow_input_arbiter #(
    .C_NUM_PORTS(N), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU),
    .C_AXIS_SPT_DATA_WIDTH(8), .C_STAT_WIDTH(STW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .grant_port(grant_port)
`ifdef OF_ARB_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SB-1:0] strb;
    logic [TU-1:0] user;
    logic          last;
    int            gap;
  } beat_t;

  beat_t src [N][$];
  beat_t exp_q [$];
  int    pop_cyc [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Input beat k of packet id: first beat carries SPT 0x00, later beats a nonzero SPT that must pass through.
  function automatic beat_t gen(int id, int k, int n);
    beat_t b;
    b.data = {32'(id), 32'(k)};
    b.strb = 8'(8'hFF >> k);
    b.user = {64'h0123_4567_89AB_CDEF, 32'(id), 8'h5A, 8'(k * 17), 16'(64 + k)};
    b.last = (k == n - 1);
    b.gap  = 0;
    return b;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add_pkt(input int p, input int id, input int n, input int gap_k, input int gap_len);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b = gen(id, k, n);
      if (k == gap_k) b.gap = gap_len;
      src[p].push_back(b);
    end
  endtask

  task automatic exp_pkt(input int id, input int n, input int k0, input int k1, input logic [7:0] spt);
    for (int k = k0; k < k1; k++) begin
      beat_t b;
      b = gen(id, k, n);
      if (k == k0) b.user[23:16] = spt;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && src[0].size() + src[1].size() + src[2].size()
          + src[3].size() + src[4].size() == 0) break;
      @(posedge aclk); #2;
    end
    if (i == budget) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge aclk);
    #2;
  endtask

  // Driver: handshake is judged mid-cycle, the next beat is presented just after the edge.
  initial begin : driver
    logic [N-1:0] fired;
    beat_t t;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0;
    forever begin
      @(negedge aclk);
      fired = s_axis_tvalid & s_axis_tready;
      @(posedge aclk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (fired[p] && src[p].size() > 0) void'(src[p].pop_front());
        s_axis_tvalid[p] = 1'b0;
        if (src[p].size() > 0) begin
          t = src[p][0];
          if (t.gap > 0) begin
            t.gap = t.gap - 1;
            src[p][0] = t;
          end else begin
            s_axis_tvalid[p]          = 1'b1;
            s_axis_tdata[p*DW +: DW]  = t.data;
            s_axis_tstrb[p*SB +: SB]  = t.strb;
            s_axis_tuser[p*TU +: TU]  = t.user;
            s_axis_tlast[p]           = t.last;
          end
        end
      end
    end
  end

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge aclk);
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: got data %0h expected no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", m_axis_tdata, e.data);
          chk("sb_strb", m_axis_tstrb, e.strb);
          chk("sb_user", m_axis_tuser, e.user);
          chk("sb_last", m_axis_tlast, e.last);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ts, tm, i;
    m_axis_tready = 1'b1;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #2;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tstrb", m_axis_tstrb, 0);
    chk("rst_m_tuser", m_axis_tuser, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_grant", grant_port, 0);
    areset = 1'b0;
    @(posedge aclk); #2;

    // Contention from reset: ptr starts at N-1 so port 0 leads, then 1, 4, repeat.
    pop_cyc.delete();
    add_pkt(0, 10, 2, -1, 0); add_pkt(1, 11, 2, -1, 0); add_pkt(4, 12, 2, -1, 0);
    add_pkt(0, 13, 2, -1, 0); add_pkt(1, 14, 2, -1, 0); add_pkt(4, 15, 2, -1, 0);
    exp_pkt(10, 2, 0, 2, 8'h01); exp_pkt(11, 2, 0, 2, 8'h02); exp_pkt(12, 2, 0, 2, 8'h10);
    exp_pkt(13, 2, 0, 2, 8'h01); exp_pkt(14, 2, 0, 2, 8'h02); exp_pkt(15, 2, 0, 2, 8'h10);
    wait_drain(200);
    chk("cont_beats", pop_cyc.size(), 12);
    if (pop_cyc.size() == 12) chk("cont_span", pop_cyc[11] - pop_cyc[0], 16);

    // Single packet on port 2 and the two-cycle valid-to-valid latency.
    add_pkt(2, 1, 3, -1, 0);
    exp_pkt(1, 3, 0, 3, 8'h04);
    ts = -1; tm = -1;
    for (i = 0; i < 20; i++) begin
      @(posedge aclk); #2;
      if (ts < 0 && s_axis_tvalid[2]) ts = cyc;
      if (m_axis_tvalid) begin tm = cyc; break; end
    end
    chk("lat_seen", {ts >= 0, tm >= 0}, 2'b11);
    chk("lat_cycles", tm - ts, 2);
    wait_drain(100);

    // Backpressure while beat 1 of port 1 sits on the output.
    add_pkt(1, 20, 4, -1, 0);
    exp_pkt(20, 4, 0, 4, 8'h02);
    for (i = 0; i < 50; i++) begin
      @(posedge aclk); #2;
      if (m_axis_tvalid && m_axis_tdata == {32'd20, 32'd1}) break;
    end
    chk("bp_reach", i < 50, 1);
    m_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #2;
      chk("bp_data", m_axis_tdata, {32'd20, 32'd1});
      chk("bp_valid", m_axis_tvalid, 1);
      chk("bp_s_tready", s_axis_tready, 0);
    end
    m_axis_tready = 1'b1;
    wait_drain(100);

    // Port 2 stalls mid-packet for 3 cycles while port 1 waits.
    add_pkt(2, 30, 3, 1, 3);
    add_pkt(1, 31, 2, -1, 0);
    exp_pkt(30, 3, 0, 3, 8'h04);
    exp_pkt(31, 2, 0, 2, 8'h02);
    for (i = 0; i < 50; i++) begin
      @(posedge aclk); #2;
      if (s_axis_tvalid[1] && !s_axis_tvalid[2]) break;
    end
    chk("gap_reach", i < 50, 1);
    for (int c = 0; c < 3; c++) begin
      chk("gap_grant", grant_port, 2);
      chk("gap_p1_tready", s_axis_tready[1], 0);
      if (c < 2) begin @(posedge aclk); #2; end
    end
    wait_drain(100);

    // Reset while beat 1 of a 4-beat port 3 packet is on the output.
    add_pkt(3, 40, 4, -1, 0);
    exp_pkt(40, 4, 0, 2, 8'h08);
    for (i = 0; i < 50; i++) begin
      @(posedge aclk); #2;
      if (m_axis_tvalid && m_axis_tdata == {32'd40, 32'd1}) break;
    end
    chk("rstmid_reach", i < 50, 1);
    areset = 1'b1;
    add_pkt(0, 41, 2, -1, 0);
    exp_pkt(41, 2, 0, 2, 8'h01);
    exp_pkt(40, 4, 2, 4, 8'h08);
    @(posedge aclk); #2;
    chk("rstmid_m_tvalid", m_axis_tvalid, 0);
    chk("rstmid_m_tdata", m_axis_tdata, 0);
    chk("rstmid_m_tuser", m_axis_tuser, 0);
    chk("rstmid_m_tlast", m_axis_tlast, 0);
    chk("rstmid_s_tready", s_axis_tready, 0);
    chk("rstmid_grant", grant_port, 0);
    areset = 1'b0;
    @(posedge aclk); #2;
    chk("rstmid_first_grant", grant_port, 0);
    wait_drain(100);

`ifdef OF_ARB_STATS_EN
    areset = 1'b1;
    @(posedge aclk); #2;
    areset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      add_pkt(3, 50 + k, 1, -1, 0);
      exp_pkt(50 + k, 1, 0, 1, 8'h08);
    end
    wait_drain(200);
    for (int p = 0; p < N; p++)
      chk("stat_count", pkt_count[p*STW +: STW], (p == 3) ? 1 : 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
